// File: rtl/parity_pkg.sv
// Shared types and constants for the parity-protected serial receiver.
package parity_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        PAR  = 2'd1,
        HOLD = 2'd2
    } rx_state_t;

    localparam int PAR_EVEN  = 0;
    localparam int PAR_ODD   = 1;
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/parity_tree.sv
// XOR reduction of a W-bit vector down to a single parity bit.
module parity_tree #(
    parameter int W = 8
) (
    input  logic [W-1:0] vec_i,
    output logic         par_o
);

    assign par_o = ^vec_i;

endmodule

// File: rtl/parity_check_rx.sv
// Serial parity-frame receiver: N data bits LSB first, one parity bit, then a held word.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_check_rx
    import parity_pkg::*;
#(
    parameter int N          = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic                 s_bit,
    output logic                 s_ready,
    input  logic                 s_clr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N-1:0]         m_data,
    output logic                 m_perr
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int   CW      = $clog2(N);
    localparam logic ODD_BIT = (PARITY_ODD != PAR_EVEN);

    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    data_q, data_d;
    logic            perr_q, perr_d;
    logic            dataPar;
    logic            xfer;

    parity_tree #(.W(N)) u_tree (
        .vec_i (data_q),
        .par_o (dataPar)
    );

    // m_valid is simply "in HOLD", so both handshake outputs come straight from state.
    assign s_ready = (state_q != HOLD);
    assign m_valid = (state_q == HOLD);
    assign m_data  = data_q;
    assign m_perr  = perr_q;
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        perr_d  = perr_q;
        unique case (state_q)
            RECV: begin
                if (s_clr) begin
                    cnt_d = '0;
                end else if (xfer) begin
                    data_d[cnt_q] = s_bit;
                    if (cnt_q == CW'(N-1)) begin
                        cnt_d   = '0;
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (s_clr) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end else if (xfer) begin
                    perr_d  = dataPar ^ s_bit ^ ODD_BIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // s_clr is deliberately ignored here so a finished word is never dropped.
                if (m_ready) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RECV;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RECV;
            cnt_q   <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
    logic                 frameBad;

    // Counts on the same edge a bad frame moves into HOLD; saturates instead of wrapping.
    assign frameBad = (state_q == PAR) && !s_clr && xfer && perr_d;

    always_comb begin
        errCnt_d = errCnt_q;
        if (frameBad && (errCnt_q != {ERR_CNT_W{1'b1}})) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed self-checking bench: an even-parity and an odd-parity receiver side by side.
module tb_parity_check_rx;

    logic       clk;
    logic       rst_n;

    logic       sValidE, sBitE, sClrE, mReadyE;
    logic       sReadyE, mValidE, mPerrE;
    logic [7:0] mDataE;

    logic       sValidO, sBitO, sClrO, mReadyO;
    logic       sReadyO, mValidO, mPerrO;
    logic [7:0] mDataO;

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] errCntE, errCntO;
`endif

    int errors = 0;
    int checks = 0;

    parity_check_rx #(.N(8), .PARITY_ODD(0)) dutEven (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (sValidE),
        .s_bit   (sBitE),
        .s_ready (sReadyE),
        .s_clr   (sClrE),
        .m_valid (mValidE),
        .m_ready (mReadyE),
        .m_data  (mDataE),
        .m_perr  (mPerrE)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt (errCntE)
`endif
    );

    parity_check_rx #(.N(8), .PARITY_ODD(1)) dutOdd (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (sValidO),
        .s_bit   (sBitO),
        .s_ready (sReadyO),
        .s_clr   (sClrO),
        .m_valid (mValidO),
        .m_ready (mReadyO),
        .m_data  (mDataO),
        .m_perr  (mPerrO)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt (errCntO)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one bit for a single cycle, then leave the check point at posedge+1.
    task automatic applyStimulus(input bit toOdd, input logic b);
        if (toOdd) begin sValidO = 1'b1; sBitO = b; end
        else       begin sValidE = 1'b1; sBitE = b; end
        @(posedge clk); #1;
        sValidE = 1'b0;
        sValidO = 1'b0;
    endtask

    task automatic sendFrame(input bit toOdd, input logic [7:0] d, input logic p);
        for (int i = 0; i < 8; i++) applyStimulus(toOdd, d[i]);
        applyStimulus(toOdd, p);
    endtask

    task automatic releaseWord(input bit toOdd);
        if (toOdd) mReadyO = 1'b1; else mReadyE = 1'b1;
        @(posedge clk); #1;
        mReadyE = 1'b0;
        mReadyO = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        sValidE = 0; sBitE = 0; sClrE = 0; mReadyE = 0;
        sValidO = 0; sBitO = 0; sClrO = 0; mReadyO = 0;
        #3;
        checkOutput("rst_s_ready", 32'(sReadyE), 32'd1);
        checkOutput("rst_m_valid", 32'(mValidE), 32'd0);
        checkOutput("rst_m_data",  32'(mDataE),  32'h00);
        checkOutput("rst_m_perr",  32'(mPerrE),  32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean even frame: two ones plus p=0
        sendFrame(0, 8'h03, 1'b0);
        checkOutput("t1_valid", 32'(mValidE), 32'd1);
        checkOutput("t1_data",  32'(mDataE),  32'h03);
        checkOutput("t1_perr",  32'(mPerrE),  32'd0);
        releaseWord(0);

        // Three ones: p=0 is an error, p=1 is clean
        sendFrame(0, 8'h07, 1'b0);
        checkOutput("t2a_data", 32'(mDataE), 32'h07);
        checkOutput("t2a_perr", 32'(mPerrE), 32'd1);
        releaseWord(0);
        sendFrame(0, 8'h07, 1'b1);
        checkOutput("t2b_perr", 32'(mPerrE), 32'd0);
        releaseWord(0);

        // Odd mode on zero data
        sendFrame(1, 8'h00, 1'b1);
        checkOutput("t3a_valid", 32'(mValidO), 32'd1);
        checkOutput("t3a_perr",  32'(mPerrO),  32'd0);
        releaseWord(1);
        sendFrame(1, 8'h00, 1'b0);
        checkOutput("t3b_perr", 32'(mPerrO), 32'd1);
        releaseWord(1);
        checkOutput("t3_odd_ready", 32'(sReadyO), 32'd1);

        // Backpressure: word held for 3 cycles, s_clr in HOLD must not drop it
        sendFrame(0, 8'h3C, 1'b0);
        for (int c = 0; c < 3; c++) begin
            sClrE = (c == 1);
            @(posedge clk); #1;
            sClrE = 1'b0;
            checkOutput("t4_s_ready", 32'(sReadyE), 32'd0);
            checkOutput("t4_m_valid", 32'(mValidE), 32'd1);
            checkOutput("t4_m_data",  32'(mDataE),  32'h3C);
            checkOutput("t4_m_perr",  32'(mPerrE),  32'd0);
        end
        releaseWord(0);
        checkOutput("t4_rel_valid", 32'(mValidE), 32'd0);
        checkOutput("t4_rel_ready", 32'(sReadyE), 32'd1);

        // Abort after 4 bits; the bit presented with s_clr is discarded
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1);
        sClrE = 1'b1;
        applyStimulus(0, 1'b1);
        sClrE = 1'b0;
        checkOutput("t5_clr_valid", 32'(mValidE), 32'd0);
        sendFrame(0, 8'hA5, 1'b0);
        checkOutput("t5a_valid", 32'(mValidE), 32'd1);
        checkOutput("t5a_data",  32'(mDataE),  32'hA5);
        checkOutput("t5a_perr",  32'(mPerrE),  32'd0);
        releaseWord(0);

        // Asynchronous reset after 5 bits of 0x5A (partial word is 0x1A)
        for (int i = 0; i < 5; i++) applyStimulus(0, (i == 1 || i == 3 || i == 4));
        rst_n = 1'b0;
        #2;
        checkOutput("t5_rst_data",  32'(mDataE),  32'h00);
        checkOutput("t5_rst_valid", 32'(mValidE), 32'd0);
        checkOutput("t5_rst_ready", 32'(sReadyE), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sendFrame(0, 8'h5A, 1'b0);
        checkOutput("t5b_valid", 32'(mValidE), 32'd1);
        checkOutput("t5b_data",  32'(mDataE),  32'h5A);
        checkOutput("t5b_perr",  32'(mPerrE),  32'd0);
        releaseWord(0);

`ifdef PARITY_ERR_CNT_EN
        checkOutput("t6_cnt0", 32'(errCntE), 32'd0);
        for (int f = 0; f < 3; f++) begin
            sendFrame(0, 8'h01, 1'b0);
            releaseWord(0);
        end
        checkOutput("t6_cnt3", 32'(errCntE), 32'd3);
        for (int f = 0; f < 257; f++) begin
            sendFrame(0, 8'h01, 1'b0);
            releaseWord(0);
        end
        checkOutput("t6_cnt_sat", 32'(errCntE), 32'd255);
        checkOutput("t6_odd_cnt", 32'(errCntO), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
- Serial receiver and checker for parity-protected frames; the receiving end of the team's parity generator.
- Shifts in N data bits (LSB first), then one parity bit, and checks the frame against the configured parity mode.
- Presents the parallel word plus an error flag on a valid/ready output.
- Sits between a serial link front end and downstream word-level logic.

Parameters:
N, 8, data bits per frame (N >= 2)
PARITY_ODD, 0, 0 = even parity (total ones in data+parity even), 1 = odd parity

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  serial bit valid
s_bit  input  1  serial bit
s_ready  output  1  receiver can accept a bit
s_clr  input  1  synchronous abort of partial frame
m_valid  output  1  received word valid
m_ready  input  1  downstream accepts word
m_data  output  N  received data word
m_perr  output  1  parity error for m_data

Behaviour:
- Reset is asynchronous, active-low; one clock; rising edge.
- Reset values: s_ready=1, m_valid=0, m_data=0, m_perr=0; state=RECV; bit count=0.
- Bit transfer: a bit transfers when s_valid && s_ready are both high on a rising clk.
- State RECV:
  - each transferred bit is written into m_data position cnt (LSB first); cnt increments.
  - after bit N-1 is transferred -> PAR.
- State PAR:
  - the transferred bit is the parity bit p.
  - total = (XOR-reduce of data) ^ p.
  - m_perr <= total ^ PARITY_ODD.
  - m_valid <= 1 (registered: asserted the cycle after the parity bit transfers) -> HOLD.
- State HOLD:
  - s_ready=0; m_data and m_perr are held stable.
  - on m_valid && m_ready: m_valid <= 0, cnt <= 0 -> RECV.
  - the next bit is accepted no earlier than the following cycle (one bubble per frame).
- s_ready = (state != HOLD).
- m_data bits are not yet written during RECV/PAR are don't-care; m_data is only meaningful while m_valid=1.
- s_clr:
  - in RECV/PAR: cnt <= 0, state <= RECV; any bit presented that cycle is discarded.
  - in HOLD: ignored; the held word is never dropped.
  - s_clr has priority over a simultaneous bit transfer.
- Reset mid-frame or mid-HOLD: everything returns immediately to reset values; the partial or held word is lost.
- cnt width: $clog2(N); it never exceeds N-1.
- No combinational path from s_* to m_*, or from m_ready to s_ready.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- When defined:
  - adds output port err_cnt, width 8: a saturating count of frames completed with m_perr=1.
  - increments on the same edge m_perr is set to 1; holds at 255.
  - cleared only by rst_n.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package parity_pkg:
  - state enum rx_state_t {RECV, PAR, HOLD}.
  - localparams PAR_EVEN=0, PAR_ODD=1.
  - ERR_CNT_W=8.
- One natural sub-module, parity_tree: parameterised XOR reduction of an N-bit vector to one bit, instantiated for the data word.
- The rest is a single FSM + datapath.

Test Plan:
1. N=8, even mode: send 0x03 LSB first (1,1,0,0,0,0,0,0), then p=0 -> m_valid=1 one cycle after p; m_data=0x03, m_perr=0.
2. Even mode: send 0x07, then p=0 -> m_data=0x07, m_perr=1. Then 0x07 with p=1 -> m_perr=0.
3. PARITY_ODD=1: send 0x00, p=1 -> m_perr=0. Send 0x00, p=0 -> m_perr=1.
4. Backpressure: complete a frame with m_ready=0 for 3 cycles -> s_ready=0 and m_data/m_perr stable throughout; m_ready=1 -> m_valid drops next cycle, s_ready=1.
5. Abort and reset: s_clr after 4 bits, then a full frame 0xA5 with p=0 -> m_data=0xA5, m_perr=0. Assert rst_n=0 after 5 bits of a frame -> all outputs return to reset values immediately; the following frame 0x5A with p=0 is received correctly.
6. With PARITY_ERR_CNT_EN: 3 bad frames -> err_cnt=3. 260 bad frames -> err_cnt=255.
